pad_direction_conditioner: RTL
==============================

Name: pad_direction_conditioner

Overview:
- Sits directly upstream of the processor skeleton's memory-mapped input ports (4100 / 4101).
- Takes four raw, asynchronous, bouncy direction buttons for one player.
- Synchronises and debounces each button, then arbitrates simultaneous presses.
- Drives the skeleton's upSig/rightSig/downSig/leftSig (or the ...2 set) as strictly one-hot-or-zero, so the skeleton never sees an unencodable combination. Two instances are used, one per player.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a button state change is accepted (10 ms at 50 MHz); must be >= 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- RAW_ACTIVE_LOW, 1, 1 = raw pins read 0 when pressed (pulled-up pads), 0 = active-high pins.

Ports:
- clock  in  1  master clock, same as skeleton.
- reset  in  1  asynchronous, active-low reset.
- raw_up  in  1  raw up button, asynchronous to clock.
- raw_right  in  1  raw right button.
- raw_down  in  1  raw down button.
- raw_left  in  1  raw left button.
- up_sig  out  1  conditioned up; feeds upSig/upSig2.
- right_sig  out  1  conditioned right.
- down_sig  out  1  conditioned down.
- left_sig  out  1  conditioned left.
- dir_code  out  3  0 none, 1 up, 2 right, 3 down, 4 left; same encoding the skeleton returns.
- dir_change  out  1  one-cycle pulse when dir_code changes.

Behaviour:
- Reset is asynchronous and active-low. While reset is low:
  - all outputs are 0;
  - synchroniser flops are cleared to the "released" level;
  - debounce FSMs are in REL with counters at 0;
  - last_dir is 0.
- Input path: each raw pin is inverted if RAW_ACTIVE_LOW, then passed through a 2-flop synchroniser on posedge clock. All logic is posedge.
- Per-button debounce FSM, states REL, PEND_PRESS, HELD, PEND_REL:
  - REL: sync=1 -> PEND_PRESS, counter cleared.
  - PEND_PRESS: sync=1 -> counter increments; when counter reaches DEBOUNCE_CYCLES-1 -> HELD. sync=0 -> REL, counter cleared (glitch rejected).
  - HELD: sync=0 -> PEND_REL, counter cleared.
  - PEND_REL: symmetric to PEND_PRESS, resolving to REL, or back to HELD on a bounce.
  - Debounced level = 1 in HELD and PEND_REL.
  - Emits a one-cycle press_evt on the PEND_PRESS->HELD transition.
  - Counter saturates and never wraps.
- Latency: raw edge -> debounced edge = 2 (sync) + DEBOUNCE_CYCLES cycles; arbitration adds 1 register stage.
- Arbitration, registered each cycle:
  - Newest press wins: on a press_evt, last_dir takes that button's code.
  - Same-cycle press_evts tie-break by fixed priority up > right > down > left.
  - When the button holding last_dir is released and others remain held, last_dir falls back to the highest-priority held button, in the same priority order.
  - When no button is held, last_dir = 0.
- Outputs:
  - up/right/down/left_sig are the one-hot decode of dir_code; never more than one is high.
  - dir_code = last_dir, registered.
  - dir_change = (next last_dir != last_dir), registered alongside.
- Reset asserted mid-debounce or mid-hold aborts immediately. After reset release, a still-held button must re-debounce the full DEBOUNCE_CYCLES before it appears.

Optional Feature:
- Macro STICKY_DIR_EN.
- Defined: when all buttons are released, dir_code keeps the last nonzero direction (Pac-Man style continued motion). It returns to 0 only on reset. Fallback-on-release among held buttons is unchanged.
- Undefined: behaviour as above, and release of all buttons gives dir_code = 0.

Decomposition:
- Shared package holds:
  - direction code constants DIR_NONE=0, DIR_UP=1, DIR_RIGHT=2, DIR_DOWN=3, DIR_LEFT=4 (shared with the skeleton's input-port decode and game software);
  - debounce FSM state encoding.
- One natural sub-module, button_debouncer (synchroniser + FSM + counter, outputs level and press_evt), instantiated four times. The top level holds arbitration and output registers.

Test Plan (DEBOUNCE_CYCLES=4, RAW_ACTIVE_LOW=0):
1. raw_up high, held -> up_sig=1, dir_code=1 exactly 7 cycles after the first sampled edge (2 sync + 4 debounce + 1); dir_change pulses once.
2. raw_right glitches high for 3 cycles -> no output change, FSM returns to REL, dir_code stays 0.
3. Hold right (dir_code=2), then press left -> dir_code=4 and only left_sig high. Release left -> dir_code=2 after debounce.
4. raw_down and raw_up rise in the same cycle -> dir_code=1. Release up -> dir_code=3.
5. Hold left, assert reset low mid-hold -> all outputs 0 immediately. Deassert with left still held -> dir_code=4 only after the full 7-cycle latency again.
6. With STICKY_DIR_EN: press then release up -> dir_code stays 1. Without the macro -> dir_code returns to 0 one cycle after the debounced release.

Source files
------------

// File: rtl/pad_direction_conditioner_pkg.sv
// Shared definitions for the per-player direction-pad conditioner.
// The direction codes match the skeleton's input-port decode and the game
// software, so changing them here breaks both of those consumers.
package pad_direction_conditioner_pkg;

  // Direction codes as returned to software through the input ports
  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_DOWN  = 3'd3;
  localparam logic [2:0] DIR_LEFT  = 3'd4;

  // Bit positions of each button inside the 4-bit button vectors
  localparam int BTN_UP    = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 3;

  // Debounce FSM states; the debounced level is high in HELD and PEND_REL
  typedef enum logic [1:0] {
    DB_REL        = 2'd0,
    DB_PEND_PRESS = 2'd1,
    DB_HELD       = 2'd2,
    DB_PEND_REL   = 2'd3
  } db_state_e;

  // Highest-priority set button in a vector, ordered up > right > down > left
  function automatic logic [2:0] pick_dir(input logic [3:0] btns);
    logic [2:0] code;
    code = DIR_NONE;
    if (btns[BTN_UP])         code = DIR_UP;
    else if (btns[BTN_RIGHT]) code = DIR_RIGHT;
    else if (btns[BTN_DOWN])  code = DIR_DOWN;
    else if (btns[BTN_LEFT])  code = DIR_LEFT;
    return code;
  endfunction

endpackage

// File: rtl/pad_direction_conditioner_button_debouncer.sv
// One button: polarity fix, 2-flop synchroniser, and a four-state debounce
// FSM with a saturating stability counter. Produces the debounced level and
// a one-cycle press event aligned with the first HELD cycle.
module button_debouncer
  import pad_direction_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int RAW_ACTIVE_LOW  = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_evt_o
);

  // The last increment before a pending state resolves; the counter then reads DEBOUNCE_CYCLES-1
  localparam logic [CNT_W-1:0] LAST_INC = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic      raw_lvl;
  logic      sync1_q, sync2_q;
  db_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic      press_evt_q;

  assign raw_lvl = (RAW_ACTIVE_LOW != 0) ? ~raw_i : raw_i;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Two-flop synchroniser, cleared to the released level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_lvl;
      sync2_q <= sync1_q;
    end
  end

  // Debounce state, counter and registered press event
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= DB_REL;
      cnt_q       <= '0;
      press_evt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_evt_q <= (state_q == DB_PEND_PRESS) && (state_d == DB_HELD);
    end
  end

  // Next-state: a change is accepted only after DEBOUNCE_CYCLES stable samples
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DB_REL: begin
        if (sync2_q) begin
          state_d = DB_PEND_PRESS;
          cnt_d   = '0;
        end
      end
      DB_PEND_PRESS: begin
        if (!sync2_q) begin
          state_d = DB_REL;
          cnt_d   = '0;
        end else if (cnt_q >= LAST_INC) begin
          state_d = DB_HELD;
          cnt_d   = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DB_HELD: begin
        if (!sync2_q) begin
          state_d = DB_PEND_REL;
          cnt_d   = '0;
        end
      end
      DB_PEND_REL: begin
        if (sync2_q) begin
          state_d = DB_HELD;
          cnt_d   = '0;
        end else if (cnt_q >= LAST_INC) begin
          state_d = DB_REL;
          cnt_d   = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = DB_REL;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: level is high while the button is considered pressed
  always_comb begin
    level_o     = (state_q == DB_HELD) || (state_q == DB_PEND_REL);
    press_evt_o = press_evt_q;
  end

endmodule

// File: rtl/pad_direction_conditioner.sv
// Per-player direction pad conditioner: four debounced buttons arbitrated
// into a single one-hot-or-zero direction for the skeleton's input ports.
// Optional build macro STICKY_DIR_EN keeps the last nonzero direction when
// every button is released (cleared only by reset).
module pad_direction_conditioner
  import pad_direction_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int RAW_ACTIVE_LOW  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_up,
  input  logic       raw_right,
  input  logic       raw_down,
  input  logic       raw_left,
  output logic       up_sig,
  output logic       right_sig,
  output logic       down_sig,
  output logic       left_sig,
  output logic [2:0] dir_code,
  output logic       dir_change
);

  logic [3:0] raw_vec, level, press_evt;
  logic [2:0] last_dir_q, last_dir_d;
  logic       dir_change_q;
  logic       cur_held;

  assign raw_vec = {raw_left, raw_down, raw_right, raw_up};

  for (genvar b = 0; b < 4; b++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RAW_ACTIVE_LOW (RAW_ACTIVE_LOW)
    ) u_db (
      .clock      (clock),
      .reset      (reset),
      .raw_i      (raw_vec[b]),
      .level_o    (level[b]),
      .press_evt_o(press_evt[b])
    );
  end

  // Is the button that currently owns the direction still held?
  always_comb begin
    cur_held = 1'b0;
    case (last_dir_q)
      DIR_UP:    cur_held = level[BTN_UP];
      DIR_RIGHT: cur_held = level[BTN_RIGHT];
      DIR_DOWN:  cur_held = level[BTN_DOWN];
      DIR_LEFT:  cur_held = level[BTN_LEFT];
      default:   cur_held = 1'b0;
    endcase
  end

  // Arbitration: newest press wins, fall back to highest-priority held button
  always_comb begin
    last_dir_d = last_dir_q;
    if (|press_evt) begin
      last_dir_d = pick_dir(press_evt);
    end else if (!cur_held) begin
      if (|level) begin
        last_dir_d = pick_dir(level);
      end else begin
`ifdef STICKY_DIR_EN
        last_dir_d = last_dir_q;
`else
        last_dir_d = DIR_NONE;
`endif
      end
    end
  end

  // Direction register and its change pulse, updated together
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_dir_q   <= DIR_NONE;
      dir_change_q <= 1'b0;
    end else begin
      last_dir_q   <= last_dir_d;
      dir_change_q <= (last_dir_d != last_dir_q);
    end
  end

  // One-hot decode of the registered direction; at most one line is high
  always_comb begin
    dir_code   = last_dir_q;
    dir_change = dir_change_q;
    up_sig     = (last_dir_q == DIR_UP);
    right_sig  = (last_dir_q == DIR_RIGHT);
    down_sig   = (last_dir_q == DIR_DOWN);
    left_sig   = (last_dir_q == DIR_LEFT);
  end

endmodule
